// File: rtl/ccss_pkg.sv
// Shared control-word bit map and ALU opcodes for the CCSS control FSM and datapath.
package ccss_pkg;

    localparam int unsigned CTRL_W          = 15;
    localparam int unsigned NUM_REGS        = 8;

    localparam int unsigned INC_DEC_EN      = 0;
    localparam int unsigned RST_DEC_EN      = 1;
    localparam int unsigned WTR_DEC_EN      = 2;
    localparam int unsigned DR_WRITE_EN     = 3;
    localparam int unsigned PC_WRITE_EN     = 4;
    localparam int unsigned OPR_SEL_LSB     = 5;
    localparam int unsigned OPR_SEL_MSB     = 7;
    localparam int unsigned MEM_READ        = 8;
    localparam int unsigned WTA_EN          = 9;
    localparam int unsigned AC_WRITE_EN     = 10;
    localparam int unsigned AC_ALU_WRITE_EN = 11;
    localparam int unsigned ALU_OP_LSB      = 12;
    localparam int unsigned ALU_OP_MSB      = 14;

    typedef logic [2:0] opr_sel_t;
    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 3'b000;
    localparam alu_op_t ALU_SUB  = 3'b001;
    localparam alu_op_t ALU_MUL  = 3'b010;
    localparam alu_op_t ALU_DIV  = 3'b011;
    localparam alu_op_t ALU_AND  = 3'b100;
    localparam alu_op_t ALU_OR   = 3'b101;
    localparam alu_op_t ALU_INC  = 3'b110;
    localparam alu_op_t ALU_ZERO = 3'b111;

endpackage

// File: rtl/ccss_alu.sv
// Combinational ALU: A op B truncated to DATA_W; divide by zero yields all-ones.
module ccss_alu
    import ccss_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output logic              div_zero
);

    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_MUL: result = a * b;
            ALU_DIV: begin
                if (b == '0) begin
                    result   = '1;
                    div_zero = 1'b1;
                end else begin
                    result = a / b;
                end
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_INC:  result = a + DATA_W'(1);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ccss_datapath.sv
// CCSS register-bank datapath: PC, DR, AC, R0..R7 and ALU driven by the control word.
module ccss_datapath
    import ccss_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] control_signal,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [1:0]        inst,
    output logic              z,
    output logic              div_err
);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] dr;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] rf [NUM_REGS];

    logic     inc_en, rst_en, wtr_en, dr_we, pc_we, mem_read;
    logic     wta_en, ac_we, ac_alu_we;
    opr_sel_t sel;
    alu_op_t  alu_op;

    logic [DATA_W-1:0] opr_c;
    logic [DATA_W-1:0] alu_result_c;
    logic              alu_div_zero_c;
    logic [DATA_W-1:0] ac_next_c;
    logic              ac_load_c;

    assign inc_en    = control_signal[INC_DEC_EN];
    assign rst_en    = control_signal[RST_DEC_EN];
    assign wtr_en    = control_signal[WTR_DEC_EN];
    assign dr_we     = control_signal[DR_WRITE_EN];
    assign pc_we     = control_signal[PC_WRITE_EN];
    assign sel       = control_signal[OPR_SEL_MSB:OPR_SEL_LSB];
    assign mem_read  = control_signal[MEM_READ];
    assign wta_en    = control_signal[WTA_EN];
    assign ac_we     = control_signal[AC_WRITE_EN];
    assign ac_alu_we = control_signal[AC_ALU_WRITE_EN];
    assign alu_op    = control_signal[ALU_OP_MSB:ALU_OP_LSB];

    assign opr_c    = rf[sel];
    assign mem_rd   = mem_read;
    assign mem_addr = pc;
    assign inst     = dr[DATA_W-1 -: 2];

    ccss_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a        (ac),
        .b        (opr_c),
        .op       (alu_op),
        .result   (alu_result_c),
        .div_zero (alu_div_zero_c)
    );

    // AC source priority: ALU > DR > R[sel]
    always_comb begin
        ac_next_c = ac;
        ac_load_c = ac_alu_we | ac_we | wta_en;
        if (ac_alu_we) begin
            ac_next_c = alu_result_c;
        end else if (ac_we) begin
            ac_next_c = dr;
        end else if (wta_en) begin
            ac_next_c = opr_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            dr      <= '0;
            ac      <= '0;
            z       <= 1'b1;
            div_err <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (pc_we) begin
                pc <= pc + ADDR_W'(1);
            end
            if (dr_we) begin
                dr <= mem_read ? mem_rdata : ac;
            end
            if (ac_load_c) begin
                ac <= ac_next_c;
                z  <= (ac_next_c == '0);
            end
            if (ac_alu_we && alu_div_zero_c) begin
                div_err <= 1'b1;
            end
            // Decoder priority on R[sel]: clear > write-from-AC > increment
            if (rst_en) begin
                rf[sel] <= '0;
            end else if (wtr_en) begin
                rf[sel] <= ac;
            end else if (inc_en) begin
                rf[sel] <= opr_c + DATA_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ccss_datapath.sv
// Directed self-checking bench for ccss_datapath.
module tb_ccss_datapath;

    logic        clk;
    logic        rst_n;
    logic [14:0] control_signal;
    logic [15:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [1:0]  inst;
    logic        z;
    logic        div_err;

    int checks;
    int failures;

    localparam logic [14:0] C_INC = 15'h0001;
    localparam logic [14:0] C_RST = 15'h0002;
    localparam logic [14:0] C_WTR = 15'h0004;
    localparam logic [14:0] C_DRW = 15'h0008;
    localparam logic [14:0] C_PCW = 15'h0010;
    localparam logic [14:0] C_MRD = 15'h0100;
    localparam logic [14:0] C_WTA = 15'h0200;
    localparam logic [14:0] C_ACW = 15'h0400;
    localparam logic [14:0] C_ALU = 15'h0800;

    ccss_datapath #(
        .DATA_W (16),
        .ADDR_W (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .control_signal (control_signal),
        .mem_rdata      (mem_rdata),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .inst           (inst),
        .z              (z),
        .div_err        (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] sel_f(input int s);
        return 15'(s) << 5;
    endfunction

    function automatic logic [14:0] op_f(input int o);
        return 15'(o) << 12;
    endfunction

    // Apply one control word across one rising edge, then idle
    task automatic step(input logic [14:0] cw, input logic [15:0] rd);
        control_signal = cw;
        mem_rdata      = rd;
        @(posedge clk);
        #1;
        control_signal = '0;
        mem_rdata      = '0;
    endtask

    task automatic load_ac(input logic [15:0] v);
        step(C_MRD | C_DRW, v);
        step(C_ACW, 16'h0);
    endtask

    task automatic load_reg(input int s, input logic [15:0] v);
        load_ac(v);
        step(C_WTR | sel_f(s), 16'h0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        load_ac(16'h1234);
        step(C_PCW, 16'h0);
        step(C_PCW, 16'h0);
        checks++;
        if (dut.ac !== 16'h1234 || z !== 1'b0 || mem_addr !== 8'h02) begin
            failures++;
            $display("FAIL pre_reset ac=%h z=%b pc=%h exp ac=1234 z=0 pc=02", dut.ac, z, mem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.ac !== 16'h0 || dut.dr !== 16'h0 || mem_addr !== 8'h0 || z !== 1'b1
            || div_err !== 1'b0 || inst !== 2'b00 || dut.rf[0] !== 16'h0) begin
            failures++;
            $display("FAIL async_reset ac=%h dr=%h pc=%h z=%b div_err=%b inst=%b exp all 0, z=1",
                     dut.ac, dut.dr, mem_addr, z, div_err, inst);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut.ac !== 16'h0 || z !== 1'b1) begin
            failures++;
            $display("FAIL reset_held ac=%h z=%b exp 0000 1", dut.ac, z);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch;
        do_reset();
        for (int i = 0; i < 5; i++) step(C_PCW, 16'h0);
        checks++;
        if (mem_addr !== 8'h05) begin
            failures++;
            $display("FAIL pc_five got=%h exp=05", mem_addr);
        end
        control_signal = C_MRD;
        #1;
        checks++;
        if (mem_rd !== 1'b1) begin
            failures++;
            $display("FAIL mem_rd_comb got=%b exp=1", mem_rd);
        end
        step(C_MRD | C_DRW, 16'h8001);
        checks++;
        if (dut.dr !== 16'h8001 || inst !== 2'b10 || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL fetch dr=%h inst=%b mem_rd=%b exp 8001 10 0", dut.dr, inst, mem_rd);
        end
        step(C_PCW, 16'h0);
        checks++;
        if (mem_addr !== 8'h06) begin
            failures++;
            $display("FAIL pc_inc got=%h exp=06", mem_addr);
        end
        for (int i = 0; i < 249; i++) step(C_PCW, 16'h0);
        checks++;
        if (mem_addr !== 8'hFF) begin
            failures++;
            $display("FAIL pc_ff got=%h exp=ff", mem_addr);
        end
        step(C_PCW, 16'h0);
        checks++;
        if (mem_addr !== 8'h00) begin
            failures++;
            $display("FAIL pc_wrap got=%h exp=00", mem_addr);
        end
    endtask

    task automatic test_regops;
        load_reg(3, 16'h0055);
        step(C_RST | sel_f(3), 16'h0);
        step(C_INC | sel_f(3), 16'h0);
        step(C_INC | sel_f(3), 16'h0);
        checks++;
        if (dut.rf[3] !== 16'h0002) begin
            failures++;
            $display("FAIL rst_inc2 got=%h exp=0002", dut.rf[3]);
        end
        load_ac(16'h00AA);
        step(C_WTR | sel_f(3), 16'h0);
        checks++;
        if (dut.rf[3] !== 16'h00AA || dut.rf[2] !== 16'h0000) begin
            failures++;
            $display("FAIL wtr r3=%h r2=%h exp 00aa 0000", dut.rf[3], dut.rf[2]);
        end
        step(C_RST | C_INC | sel_f(3), 16'h0);
        checks++;
        if (dut.rf[3] !== 16'h0000) begin
            failures++;
            $display("FAIL rst_over_inc got=%h exp=0000", dut.rf[3]);
        end
        load_reg(6, 16'hFFFF);
        step(C_INC | sel_f(6), 16'h0);
        checks++;
        if (dut.rf[6] !== 16'h0000) begin
            failures++;
            $display("FAIL inc_wrap got=%h exp=0000", dut.rf[6]);
        end
        load_reg(6, 16'h0010);
        step(C_WTR | C_INC | sel_f(6), 16'h0);
        checks++;
        if (dut.rf[6] !== 16'h0010) begin
            failures++;
            $display("FAIL wtr_over_inc got=%h exp=0010", dut.rf[6]);
        end
    endtask

    task automatic test_alu;
        load_reg(2, 16'h0007);
        load_ac(16'h0007);
        step(C_ALU | sel_f(2) | op_f(1), 16'h0);
        checks++;
        if (dut.ac !== 16'h0000 || z !== 1'b1) begin
            failures++;
            $display("FAIL alu_sub ac=%h z=%b exp 0000 1", dut.ac, z);
        end
        load_reg(2, 16'h0100);
        load_ac(16'h0100);
        step(C_ALU | sel_f(2) | op_f(2), 16'h0);
        checks++;
        if (dut.ac !== 16'h0000 || z !== 1'b1) begin
            failures++;
            $display("FAIL alu_mul ac=%h z=%b exp 0000 1", dut.ac, z);
        end
        load_ac(16'h0005);
        step(C_ALU | sel_f(2) | op_f(0), 16'h0);
        checks++;
        if (dut.ac !== 16'h0105 || z !== 1'b0) begin
            failures++;
            $display("FAIL alu_add ac=%h z=%b exp 0105 0", dut.ac, z);
        end
        load_reg(2, 16'h0007);
        load_ac(16'h0064);
        step(C_ALU | sel_f(2) | op_f(3), 16'h0);
        checks++;
        if (dut.ac !== 16'h000E || div_err !== 1'b0) begin
            failures++;
            $display("FAIL alu_div ac=%h div_err=%b exp 000e 0", dut.ac, div_err);
        end
        load_reg(4, 16'h0F0C);
        load_ac(16'h33F3);
        step(C_ALU | sel_f(4) | op_f(4), 16'h0);
        checks++;
        if (dut.ac !== 16'h0300) begin
            failures++;
            $display("FAIL alu_and got=%h exp=0300", dut.ac);
        end
        step(C_ALU | sel_f(4) | op_f(5), 16'h0);
        checks++;
        if (dut.ac !== 16'h0F0C) begin
            failures++;
            $display("FAIL alu_or got=%h exp=0f0c", dut.ac);
        end
        step(C_ALU | sel_f(4) | op_f(6), 16'h0);
        checks++;
        if (dut.ac !== 16'h0F0D) begin
            failures++;
            $display("FAIL alu_inc got=%h exp=0f0d", dut.ac);
        end
    endtask

    task automatic test_div_zero;
        do_reset();
        step(sel_f(1) | op_f(3), 16'h0);
        checks++;
        if (div_err !== 1'b0) begin
            failures++;
            $display("FAIL div_no_commit got=%b exp=0", div_err);
        end
        load_ac(16'h0010);
        step(C_ALU | sel_f(1) | op_f(3), 16'h0);
        checks++;
        if (dut.ac !== 16'hFFFF || z !== 1'b0 || div_err !== 1'b1) begin
            failures++;
            $display("FAIL div_zero ac=%h z=%b div_err=%b exp ffff 0 1", dut.ac, z, div_err);
        end
        step(C_ALU | sel_f(1) | op_f(6), 16'h0);
        checks++;
        if (dut.ac !== 16'h0000 || z !== 1'b1 || div_err !== 1'b1) begin
            failures++;
            $display("FAIL div_sticky ac=%h z=%b div_err=%b exp 0000 1 1", dut.ac, z, div_err);
        end
        do_reset();
        checks++;
        if (div_err !== 1'b0) begin
            failures++;
            $display("FAIL div_clear got=%b exp=0", div_err);
        end
    endtask

    task automatic test_priority;
        load_reg(4, 16'h0055);
        load_ac(16'h0077);
        step(C_ALU | C_ACW | C_WTA | sel_f(4) | op_f(7), 16'h0);
        checks++;
        if (dut.ac !== 16'h0000 || z !== 1'b1) begin
            failures++;
            $display("FAIL prio_alu ac=%h z=%b exp 0000 1", dut.ac, z);
        end
        step(C_ACW | C_WTA | sel_f(4), 16'h0);
        checks++;
        if (dut.ac !== 16'h0077 || z !== 1'b0) begin
            failures++;
            $display("FAIL prio_acw ac=%h z=%b exp 0077 0", dut.ac, z);
        end
        step(C_WTA | sel_f(4), 16'h0);
        checks++;
        if (dut.ac !== 16'h0055) begin
            failures++;
            $display("FAIL wta got=%h exp=0055", dut.ac);
        end
        step(C_WTR | C_ALU | sel_f(5) | op_f(6), 16'h0);
        checks++;
        if (dut.rf[5] !== 16'h0055 || dut.ac !== 16'h0056) begin
            failures++;
            $display("FAIL pre_edge r5=%h ac=%h exp 0055 0056", dut.rf[5], dut.ac);
        end
        step(C_DRW, 16'hBEEF);
        checks++;
        if (dut.dr !== 16'h0056 || inst !== 2'b00) begin
            failures++;
            $display("FAIL dr_from_ac dr=%h inst=%b exp 0056 00", dut.dr, inst);
        end
    endtask

    task automatic test_hold;
        logic [7:0] pc_q;
        pc_q = mem_addr;
        for (int i = 0; i < 3; i++) step(15'h0, 16'hFFFF);
        checks++;
        if (dut.ac !== 16'h0056 || dut.dr !== 16'h0056 || dut.rf[5] !== 16'h0055
            || mem_addr !== pc_q || z !== 1'b0) begin
            failures++;
            $display("FAIL hold ac=%h dr=%h r5=%h pc=%h z=%b exp 0056 0056 0055 %h 0",
                     dut.ac, dut.dr, dut.rf[5], mem_addr, pc_q, z);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        control_signal = '0;
        mem_rdata      = '0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_fetch();
        test_regops();
        test_alu();
        test_div_zero();
        test_priority();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
